// File: rtl/vga_timing_pkg.sv
// Shared constants and elaboration helpers for the parametrised VGA/panel timing generator.
// Defaults describe the 480x272 panel (525 x 286 totals).
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE = 480;
   localparam int DEF_H_FP     = 2;
   localparam int DEF_H_SYNC   = 41;
   localparam int DEF_H_BP     = 2;
   localparam int DEF_V_ACTIVE = 272;
   localparam int DEF_V_FP     = 2;
   localparam int DEF_V_SYNC   = 10;
   localparam int DEF_V_BP     = 2;

   localparam logic POL_LOW  = 1'b0;
   localparam logic POL_HIGH = 1'b1;

   typedef enum logic [1:0] {
      PH_SYNC   = 2'd0,
      PH_BP     = 2'd1,
      PH_ACTIVE = 2'd2,
      PH_FP     = 2'd3
   } axis_phase_e;

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return sync + bp + active + fp;
   endfunction

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int width_of(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Timing bundle between the generator (master) and the renderer (slave).
// The renderer side supplies the pixel clock-enable.
interface vga_timing_if #(
   parameter int X_W     = 9,
   parameter int Y_W     = 9,
   parameter int FRAME_W = 16
);
   logic               pix_ce;
   logic               hsync;
   logic               vsync;
   logic               hden;
   logic               vden;
   logic               de;
   logic [X_W-1:0]     pos_x;
   logic [Y_W-1:0]     pos_y;
   logic               line_start;
   logic               frame_start;
   logic               start;
   logic [FRAME_W-1:0] frame_count;
   logic               tick;
   logic               tick_toggle;

   modport master (
      input  pix_ce,
      output hsync, vsync, hden, vden, de, pos_x, pos_y,
      output line_start, frame_start, start, frame_count, tick, tick_toggle
   );

   modport slave (
      output pix_ce,
      input  hsync, vsync, hden, vden, de, pos_x, pos_y,
      input  line_start, frame_start, start, frame_count, tick, tick_toggle
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter (sync, back porch, active, front porch) with
// registered sync/active/position decode aligned to the count currently held.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int   ACTIVE = DEF_H_ACTIVE,
   parameter int   FP     = DEF_H_FP,
   parameter int   SYNC   = DEF_H_SYNC,
   parameter int   BP     = DEF_H_BP,
   parameter logic POL    = POL_LOW,
   parameter int   CW     = width_of(axis_total(ACTIVE, FP, SYNC, BP)),
   parameter int   PW     = width_of(ACTIVE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   output logic          tc,
   output logic          sync,
   output logic          active,
   output logic          active_nxt,
   output logic [PW-1:0] pos
);

   localparam int            TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
   localparam logic [CW-1:0] SYNC_END = CW'(SYNC);
   localparam logic [CW-1:0] ACT_LO   = CW'(SYNC + BP);
   localparam logic [CW-1:0] ACT_HI   = CW'(SYNC + BP + ACTIVE);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sync_q, sync_d;
   logic          active_q, active_d;
   logic [PW-1:0] pos_q, pos_d;
   axis_phase_e   phase_s;

   // Next count: advance on ce, wrap after the last front-porch position.
   always_comb begin
      cnt_d = cnt_q;
      if (ce) begin
         if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Decode the phase of the next count so the registered outputs line up with cnt_q.
   always_comb begin
      if (cnt_d < SYNC_END) begin
         phase_s = PH_SYNC;
      end else if (cnt_d < ACT_LO) begin
         phase_s = PH_BP;
      end else if (cnt_d < ACT_HI) begin
         phase_s = PH_ACTIVE;
      end else begin
         phase_s = PH_FP;
      end
   end

   always_comb begin
      sync_d   = ~POL;
      active_d = 1'b0;
      pos_d    = {PW{1'b0}};
      case (phase_s)
         PH_SYNC: begin
            sync_d = POL;
         end
         PH_ACTIVE: begin
            active_d = 1'b1;
            pos_d    = PW'(cnt_d - ACT_LO);
         end
         default: begin
            sync_d   = ~POL;
            active_d = 1'b0;
         end
      endcase
   end

   // Reset parks the axis on its last position so the first enable lands on zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= LAST;
         sync_q   <= ~POL;
         active_q <= 1'b0;
         pos_q    <= {PW{1'b0}};
      end else begin
         cnt_q    <= cnt_d;
         sync_q   <= sync_d;
         active_q <= active_d;
         pos_q    <= pos_d;
      end
   end

   assign tc         = (cnt_q == LAST);
   assign sync       = sync_q;
   assign active     = active_q;
   assign active_nxt = active_d;
   assign pos        = pos_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised panel timing generator: syncs, data enables, coordinates, strobes,
// frame counter, startup blanking and a free-running slow tick.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE     = DEF_H_ACTIVE,
   parameter int   H_FP         = DEF_H_FP,
   parameter int   H_SYNC       = DEF_H_SYNC,
   parameter int   H_BP         = DEF_H_BP,
   parameter int   V_ACTIVE     = DEF_V_ACTIVE,
   parameter int   V_FP         = DEF_V_FP,
   parameter int   V_SYNC       = DEF_V_SYNC,
   parameter int   V_BP         = DEF_V_BP,
   parameter logic HSYNC_POL    = POL_LOW,
   parameter logic VSYNC_POL    = POL_LOW,
   parameter int   START_FRAMES = 10,
   parameter int   TICK_DIV     = 4000000,
   parameter int   FRAME_W      = 16
) (
   input  logic            vgaclk,
   input  logic            reset,
   vga_timing_if.master    vif
);

   localparam int XW = width_of(H_ACTIVE);
   localparam int YW = width_of(V_ACTIVE);
   localparam int SW = width_of(START_FRAMES + 1);
   localparam int TW = width_of(TICK_DIV);

   localparam logic [SW-1:0]      START_LAST = SW'(START_FRAMES);
   localparam logic [SW-1:0]      SC_ONE     = SW'(1);
   localparam logic [TW-1:0]      TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [TW-1:0]      TC_ONE     = TW'(1);
   localparam logic [FRAME_W-1:0] FC_ONE     = FRAME_W'(1);
   localparam logic               START_INIT = (START_FRAMES != 0) ? 1'b1 : 1'b0;

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
      $error("vga_timing_gen: every timing parameter must be at least 1");
   end
   if (TICK_DIV < 2) begin : g_bad_tick
      $error("vga_timing_gen: TICK_DIV must be at least 2");
   end

   logic          h_tc_s, h_sync_s, h_act_s, h_act_nxt_s;
   logic          v_tc_s, v_sync_s, v_act_s, v_act_nxt_s;
   logic [XW-1:0] pos_x_s;
   logic [YW-1:0] pos_y_s;
   logic          line_edge_s, frame_edge_s, v_ce_s;

   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;
   logic               first_seen_q, first_seen_d;
   logic [FRAME_W-1:0] frame_count_q, frame_count_d;
   logic               start_q, start_d;
   logic [SW-1:0]      start_cnt_q, start_cnt_d;
   logic               de_q, de_d;
   logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
   logic               tick_q, tick_d;
   logic               tick_toggle_q, tick_toggle_d;

   assign line_edge_s  = vif.pix_ce & h_tc_s;
   assign v_ce_s       = line_edge_s;
   assign frame_edge_s = line_edge_s & v_tc_s;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP),
      .POL    (HSYNC_POL), .PW (XW)
   ) u_h_axis (
      .clk        (vgaclk),
      .rst        (reset),
      .ce         (vif.pix_ce),
      .tc         (h_tc_s),
      .sync       (h_sync_s),
      .active     (h_act_s),
      .active_nxt (h_act_nxt_s),
      .pos        (pos_x_s)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP),
      .POL    (VSYNC_POL), .PW (YW)
   ) u_v_axis (
      .clk        (vgaclk),
      .rst        (reset),
      .ce         (v_ce_s),
      .tc         (v_tc_s),
      .sync       (v_sync_s),
      .active     (v_act_s),
      .active_nxt (v_act_nxt_s),
      .pos        (pos_y_s)
   );

   // The first frame edge after reset only arms the counter; blanking ends on edge START_FRAMES+1.
   always_comb begin
      line_start_d  = line_edge_s;
      frame_start_d = frame_edge_s;
      first_seen_d  = first_seen_q;
      frame_count_d = frame_count_q;
      start_d       = start_q;
      start_cnt_d   = start_cnt_q;
      if (frame_edge_s) begin
         if (first_seen_q) begin
            frame_count_d = frame_count_q + FC_ONE;
         end else begin
            first_seen_d = 1'b1;
         end
         if (start_q) begin
            if (start_cnt_q == START_LAST) begin
               start_d = 1'b0;
            end else begin
               start_cnt_d = start_cnt_q + SC_ONE;
            end
         end else begin
            start_cnt_d = start_cnt_q;
         end
      end else begin
         frame_count_d = frame_count_q;
      end
      de_d = h_act_nxt_s & v_act_nxt_s & ~start_d;
   end

   // Tick divider ignores pix_ce.
   always_comb begin
      if (tick_cnt_q == TICK_LAST) begin
         tick_cnt_d    = {TW{1'b0}};
         tick_d        = 1'b1;
         tick_toggle_d = ~tick_toggle_q;
      end else begin
         tick_cnt_d    = tick_cnt_q + TC_ONE;
         tick_d        = 1'b0;
         tick_toggle_d = tick_toggle_q;
      end
   end

   always_ff @(posedge vgaclk or posedge reset) begin
      if (reset) begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         first_seen_q  <= 1'b0;
         frame_count_q <= {FRAME_W{1'b0}};
         start_q       <= START_INIT;
         start_cnt_q   <= {SW{1'b0}};
         de_q          <= 1'b0;
         tick_cnt_q    <= {TW{1'b0}};
         tick_q        <= 1'b0;
         tick_toggle_q <= 1'b0;
      end else begin
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         first_seen_q  <= first_seen_d;
         frame_count_q <= frame_count_d;
         start_q       <= start_d;
         start_cnt_q   <= start_cnt_d;
         de_q          <= de_d;
         tick_cnt_q    <= tick_cnt_d;
         tick_q        <= tick_d;
         tick_toggle_q <= tick_toggle_d;
      end
   end

   assign vif.hsync       = h_sync_s;
   assign vif.vsync       = v_sync_s;
   assign vif.hden        = h_act_s;
   assign vif.vden        = v_act_s;
   assign vif.de          = de_q;
   assign vif.pos_x       = pos_x_s;
   assign vif.pos_y       = pos_y_s;
   assign vif.line_start  = line_start_q;
   assign vif.frame_start = frame_start_q;
   assign vif.start       = start_q;
   assign vif.frame_count = frame_count_q;
   assign vif.tick        = tick_q;
   assign vif.tick_toggle = tick_toggle_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a small-timing instance (H_TOTAL=8, V_TOTAL=6) checked every cycle
// against hand-derived expectations, plus a default-parameter instance for panel timing.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

   logic vgaclk = 1'b0;
   logic s_rst;
   logic d_rst;

   always #5 vgaclk = ~vgaclk;

   vga_timing_if #(.X_W(2), .Y_W(2), .FRAME_W(16)) s_if ();
   vga_timing_if #(.X_W(9), .Y_W(9), .FRAME_W(16)) d_if ();

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
      .START_FRAMES(2), .TICK_DIV(5), .FRAME_W(16)
   ) u_small (
      .vgaclk (vgaclk),
      .reset  (s_rst),
      .vif    (s_if.master)
   );

   vga_timing_gen u_dflt (
      .vgaclk (vgaclk),
      .reset  (d_rst),
      .vif    (d_if.master)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Small-instance expectation state
   int   h_m, v_m, fc_m, fs_n, tk_m, cyc;
   logic ls_m, fs_m, start_m, tick_m, tog_m;

   // Observed event record
   int   ls_n, tk_n, start_fall, fc_at_fall, first_de, de_blank, hden_seen, vden_seen;
   int   ls_cyc [4];
   int   tk_cyc [3];
   logic tk_tog [3];
   logic prev_start;

   task automatic model_init();
      h_m = 7; v_m = 5; fc_m = 0; fs_n = 0; tk_m = 0;
      ls_m = 1'b0; fs_m = 1'b0; start_m = 1'b1; tick_m = 1'b0; tog_m = 1'b0;
   endtask

   task automatic clear_obs();
      ls_n = 0; tk_n = 0; start_fall = -1; fc_at_fall = -1; first_de = -1;
      de_blank = 0; hden_seen = 0; vden_seen = 0; prev_start = 1'b1;
   endtask

   task automatic model_edge(input logic ce);
      if (tk_m == 4) begin
         tk_m = 0; tick_m = 1'b1; tog_m = ~tog_m;
      end else begin
         tk_m++; tick_m = 1'b0;
      end
      if (ce) begin
         if (h_m == 7) begin
            h_m = 0;
            v_m = (v_m == 5) ? 0 : v_m + 1;
         end else begin
            h_m++;
         end
         ls_m = (h_m == 0);
         fs_m = (h_m == 0) && (v_m == 0);
         if (fs_m) begin
            fs_n++;
            if (fs_n > 1) fc_m++;
            if (fs_n == 3) start_m = 1'b0;
         end
      end else begin
         ls_m = 1'b0;
         fs_m = 1'b0;
      end
   endtask

   task automatic check_model();
      logic e_hs, e_vs, e_hd, e_vd, e_de;
      int   e_px, e_py;
      e_hs = (h_m < 2) ? 1'b0 : 1'b1;
      e_vs = (v_m < 1) ? 1'b0 : 1'b1;
      e_hd = (h_m >= 3) && (h_m < 7);
      e_vd = (v_m >= 2) && (v_m < 5);
      e_de = e_hd & e_vd & ~start_m;
      e_px = e_hd ? h_m - 3 : 0;
      e_py = e_vd ? v_m - 2 : 0;
      chk("syncs",       32'({s_if.hsync, s_if.vsync}), 32'({e_hs, e_vs}));
      chk("hden_vden_de", 32'({s_if.hden, s_if.vden, s_if.de}), 32'({e_hd, e_vd, e_de}));
      chk("pos_x",       32'(s_if.pos_x), 32'(e_px));
      chk("pos_y",       32'(s_if.pos_y), 32'(e_py));
      chk("strobes",     32'({s_if.line_start, s_if.frame_start}), 32'({ls_m, fs_m}));
      chk("start",       32'(s_if.start), 32'(start_m));
      chk("frame_count", 32'(s_if.frame_count), 32'(fc_m));
      chk("tick",        32'({s_if.tick, s_if.tick_toggle}), 32'({tick_m, tog_m}));
   endtask

   task automatic observe();
      if (s_if.line_start) begin
         if (ls_n < 4) ls_cyc[ls_n] = cyc;
         ls_n++;
      end
      if (s_if.tick) begin
         if (tk_n < 3) begin
            tk_cyc[tk_n] = cyc;
            tk_tog[tk_n] = s_if.tick_toggle;
         end
         tk_n++;
      end
      if (prev_start && !s_if.start && start_fall < 0) begin
         start_fall = cyc;
         fc_at_fall = int'(s_if.frame_count);
      end
      if (s_if.de && first_de < 0) first_de = cyc;
      if (cyc <= 96) begin
         if (s_if.de) de_blank++;
         if (s_if.hden) hden_seen++;
         if (s_if.vden) vden_seen++;
      end
      prev_start = s_if.start;
   endtask

   task automatic run(input int n, input bit alt);
      for (int i = 0; i < n; i++) begin
         @(posedge vgaclk);
         model_edge(s_if.pix_ce);
         cyc++;
         @(negedge vgaclk);
         check_model();
         observe();
         s_if.pix_ce = alt ? ~s_if.pix_ce : 1'b1;
      end
   endtask

   task automatic chk_reset_small(input string tag);
      chk({tag, "_syncs"},  32'({s_if.hsync, s_if.vsync}), 32'(2'b11));
      chk({tag, "_dens"},   32'({s_if.hden, s_if.vden, s_if.de}), 32'(3'b000));
      chk({tag, "_pos"},    32'({s_if.pos_x, s_if.pos_y}), 32'(4'h0));
      chk({tag, "_strobe"}, 32'({s_if.line_start, s_if.frame_start}), 32'(2'b00));
      chk({tag, "_start"},  32'(s_if.start), 32'(1'b1));
      chk({tag, "_fcnt"},   32'(s_if.frame_count), 32'(16'h0000));
      chk({tag, "_tick"},   32'({s_if.tick, s_if.tick_toggle}), 32'(2'b00));
   endtask

   task automatic check_blanking_run(input string tag);
      chk({tag, "_start_fall_cyc"}, 32'(start_fall), 32'(97));
      chk({tag, "_fcnt_at_fall"},   32'(fc_at_fall), 32'(2));
      chk({tag, "_de_in_blank"},    32'(de_blank), 32'(0));
      chk({tag, "_hden_in_blank"},  32'(hden_seen), 32'(48));
      chk({tag, "_vden_in_blank"},  32'(vden_seen), 32'(48));
      chk({tag, "_first_de_cyc"},   32'(first_de), 32'(116));
   endtask

   initial begin
      int found;
      int d_ls_n, d_ls0, d_ls1, d_hs_low, d_hden, d_vs_low, d_vden_rise, d_de;

      s_rst = 1'b1;
      d_rst = 1'b1;
      s_if.pix_ce = 1'b1;
      d_if.pix_ce = 1'b1;
      model_init();
      clear_obs();
      cyc = 0;

      repeat (2) @(negedge vgaclk);
      chk_reset_small("rst");
      chk("dflt_rst_syncs", 32'({d_if.hsync, d_if.vsync, d_if.start}), 32'(3'b111));

      // Release and run through two blanked frames into the first visible one.
      s_rst = 1'b0;
      run(1, 1'b0);
      chk("first_edge", 32'({s_if.frame_start, s_if.line_start, s_if.hsync, s_if.vsync}),
          32'(4'b1100));
      run(129, 1'b0);
      chk("ls_first_cyc", 32'(ls_cyc[0]), 32'(1));
      chk("ls_period",    32'(ls_cyc[1] - ls_cyc[0]), 32'(8));
      chk("tick_cycles",  32'({8'(tk_cyc[0]), 8'(tk_cyc[1]), 8'(tk_cyc[2])}), 32'(24'h050A0F));
      chk("tick_toggles", 32'({tk_tog[0], tk_tog[1], tk_tog[2]}), 32'(3'b101));
      check_blanking_run("blank1");

      // Pixel enable every other cycle stretches the line to 16 cycles.
      ls_n = 0;
      run(48, 1'b1);
      chk("ce_half_ls_count", 32'(ls_n >= 2), 32'(1'b1));
      chk("ce_half_ls_period", 32'(ls_cyc[1] - ls_cyc[0]), 32'(16));

      // Reset between edges at h=5, v=3.
      found = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         run(1, 1'b0);
         if (h_m == 5 && v_m == 3) found = 1;
      end
      chk("reach_h5v3", 32'(found), 32'(1));
      s_rst = 1'b1;
      #1;
      chk_reset_small("midrst");
      @(negedge vgaclk);
      chk_reset_small("midrst_hold");
      model_init();
      clear_obs();
      cyc = 0;
      s_rst = 1'b0;
      run(130, 1'b0);
      check_blanking_run("blank2");

      // Default panel timing.
      d_ls_n = 0; d_ls0 = -1; d_ls1 = -1; d_hs_low = 0; d_hden = 0;
      d_vs_low = 0; d_vden_rise = -1; d_de = 0;
      d_rst = 1'b0;
      for (int k = 1; k <= 6400; k++) begin
         @(negedge vgaclk);
         if (d_if.line_start) begin
            if (d_ls_n == 0) d_ls0 = k;
            if (d_ls_n == 1) d_ls1 = k;
            d_ls_n++;
         end
         if (k <= 525 && !d_if.hsync) d_hs_low++;
         if (k <= 525 && d_if.hden) d_hden++;
         if (!d_if.vsync) d_vs_low++;
         if (d_if.vden && d_vden_rise < 0) d_vden_rise = k;
         if (d_if.de) d_de++;
      end
      chk("dflt_ls_first",   32'(d_ls0), 32'(1));
      chk("dflt_line_len",   32'(d_ls1 - d_ls0), 32'(525));
      chk("dflt_hsync_low",  32'(d_hs_low), 32'(41));
      chk("dflt_hden_high",  32'(d_hden), 32'(480));
      chk("dflt_vsync_low",  32'(d_vs_low), 32'(5250));
      chk("dflt_vden_rise",  32'(d_vden_rise), 32'(6301));
      chk("dflt_de_blanked", 32'(d_de), 32'(0));
      chk("dflt_start_fcnt", 32'({d_if.start, d_if.frame_count}), 32'({1'b1, 16'h0000}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
